fb_line_writer: RTL and testbench

Frame-buffer write master in the `mem_clk` domain, directly upstream of the VGA scan-out path. It accepts a stream of 128-bit pixel words and writes them to DDR as AXI4 write bursts, one scanline at a time. Each line starts at `base_addr + line*pitch`, the same layout the display read path fetches. Bursts are split at `MAX_BURST` beats and at every 4 KB boundary, and `done` pulses once every write response for the frame has returned.

---
 rtl/vga_pkg.sv | 17 +
 rtl/fbw_burst_calc.sv | 23 ++
 rtl/fb_line_writer.sv | 185 ++++++++++++++++++
 tb/tb_fb_line_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: AXI constants and the state type shared by the frame-buffer write path
package vga_pkg;

    localparam logic [1:0] AXI4_OKAY    = 2'b00;
    localparam logic [1:0] AXI4_SLVERR  = 2'b10;
    localparam logic [2:0] AXSIZE_16B   = 3'b100;
    localparam logic [1:0] AXBURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        CS_IDLE,
        CS_AW,
        CS_W,
        CS_NEXT,
        CS_DRAIN
    } fbw_cs_t;

endpackage

// File: rtl/fbw_burst_calc.sv
// fbw_burst_calc: beats for the next burst, limited by words left, MAX_BURST and the 4 KB page end
module fbw_burst_calc #(
    parameter int MAX_BURST = 16
) (
    input  logic [11:0] cur_addr,
    input  logic [8:0]  words_left,
    output logic [12:0] len
);

    logic [12:0] room;
    logic [12:0] words;
    logic [12:0] cap;

    // smallest of the three limits; the address is 16-byte aligned so room is never 0
    always_comb begin
        room  = (13'h1000 - {1'b0, cur_addr}) >> 4;
        words = {4'b0, words_left};
        cap   = 13'(MAX_BURST);
        len   = (words < cap) ? words : cap;
        len   = (room < len) ? room : len;
    end

endmodule

// File: rtl/fb_line_writer.sv
// fb_line_writer: writes a pixel stream to DDR as AXI4 bursts, one scanline at a time
module fb_line_writer
    import vga_pkg::*;
#(
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         mem_clk,
    input  logic         mem_reset_n,
    input  logic         start,
    input  logic [26:0]  base_addr,
    input  logic [12:0]  pitch,
    input  logic [8:0]   line_words,
    input  logic [11:0]  line_count,
    output logic         busy,
    output logic         done,
    output logic         err,
    input  logic         pix_valid,
    output logic         pix_ready,
    input  logic [127:0] pix_data,
    output logic [3:0]   mem_awid,
    output logic [26:0]  mem_awaddr,
    output logic [7:0]   mem_awlen,
    output logic [2:0]   mem_awsize,
    output logic [1:0]   mem_awburst,
    output logic         mem_awlock,
    output logic         mem_awvalid,
    input  logic         mem_awready,
    output logic [127:0] mem_wdata,
    output logic [15:0]  mem_wstrb,
    output logic         mem_wlast,
    output logic         mem_wvalid,
    input  logic         mem_wready,
    input  logic [3:0]   mem_bid,
    input  logic [1:0]   mem_bresp,
    input  logic         mem_bvalid,
    output logic         mem_bready
);

    fbw_cs_t     state;
    logic [26:0] line_addr;
    logic [26:0] cur_addr;
    logic [12:0] pitch_q;
    logic [8:0]  line_words_q;
    logic [8:0]  words_left;
    logic [11:0] lines_left;
    logic [7:0]  beat;
    logic [3:0]  outst;

    logic [26:0] next_line;
    logic [26:0] calc_addr;
    logic [8:0]  calc_words;
    logic [12:0] len;
    logic [8:0]  burst_len;
    logic        new_line;
    logic        in_w;
    logic        start_ok;
    logic        aw_hs;
    logic        w_hs;
    logic        b_dec;
    logic        room_ok;
    logic        bid_unused;

    assign mem_awid    = '0;
    assign mem_awsize  = AXSIZE_16B;
    assign mem_awburst = AXBURST_INCR;
    assign mem_awlock  = 1'b0;
    assign mem_wstrb   = '1;
    assign mem_bready  = 1'b1;
    assign bid_unused  = ^mem_bid;

    assign next_line = line_addr + {14'b0, pitch_q};
    assign burst_len = {1'b0, mem_awlen} + 9'd1;
    assign in_w      = (state == CS_W);
    assign start_ok  = (state == CS_IDLE) && start && !busy;
    assign aw_hs     = mem_awvalid && mem_awready;
    assign w_hs      = in_w && pix_valid && mem_wready;
    assign b_dec     = mem_bvalid && ((outst != 4'd0) || aw_hs);
    assign room_ok   = outst < 4'(MAX_OUTSTANDING);

    assign mem_wvalid = in_w && pix_valid;
    assign pix_ready  = in_w && mem_wready;
    assign mem_wdata  = in_w ? pix_data : '0;
    assign mem_wlast  = in_w && (beat == mem_awlen);

    // burst sizing looks ahead to the address/words the next AW will carry
    always_comb begin
        new_line   = (state == CS_NEXT) && (words_left == 9'd0);
        calc_addr  = (state == CS_IDLE) ? base_addr : new_line ? next_line : cur_addr;
        calc_words = (state == CS_IDLE) ? line_words : new_line ? line_words_q : words_left;
    end

    fbw_burst_calc #(
        .MAX_BURST (MAX_BURST)
    ) u_calc (
        .cur_addr   (calc_addr[11:0]),
        .words_left (calc_words),
        .len        (len)
    );

    // frame sequencing: one AW then its W beats, line by line, then wait for all responses
    always_ff @(posedge mem_clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            state        <= CS_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            mem_awvalid  <= 1'b0;
            mem_awaddr   <= '0;
            mem_awlen    <= '0;
            line_addr    <= '0;
            cur_addr     <= '0;
            pitch_q      <= '0;
            line_words_q <= '0;
            words_left   <= '0;
            lines_left   <= '0;
            beat         <= '0;
        end else begin
            done <= 1'b0;
            if (done) busy <= 1'b0;
            case (state)
                CS_IDLE: if (start_ok) begin
                    pitch_q      <= pitch;
                    line_words_q <= line_words;
                    lines_left   <= line_count;
                    line_addr    <= base_addr;
                    cur_addr     <= base_addr;
                    words_left   <= line_words;
                    busy         <= 1'b1;
                    mem_awvalid  <= 1'b1;
                    mem_awaddr   <= calc_addr;
                    mem_awlen    <= 8'(len - 13'd1);
                    state        <= CS_AW;
                end
                CS_AW: if (aw_hs) begin
                    mem_awvalid <= 1'b0;
                    beat        <= '0;
                    state       <= CS_W;
                end else if (!mem_awvalid && room_ok) begin
                    mem_awvalid <= 1'b1;
                    mem_awaddr  <= calc_addr;
                    mem_awlen   <= 8'(len - 13'd1);
                end
                CS_W: if (w_hs) begin
                    beat <= beat + 8'd1;
                    if (mem_wlast) begin
                        cur_addr   <= cur_addr + {14'b0, burst_len, 4'b0};
                        words_left <= words_left - burst_len;
                        state      <= CS_NEXT;
                    end
                end
                CS_NEXT: if (!new_line || lines_left != 12'd1) begin
                    if (new_line) begin
                        line_addr  <= next_line;
                        cur_addr   <= next_line;
                        words_left <= line_words_q;
                        lines_left <= lines_left - 12'd1;
                    end
                    mem_awvalid <= room_ok;
                    mem_awaddr  <= calc_addr;
                    mem_awlen   <= 8'(len - 13'd1);
                    state       <= CS_AW;
                end else begin
                    state <= CS_DRAIN;
                end
                CS_DRAIN: if (outst == 4'd0) begin
                    done  <= 1'b1;
                    state <= CS_IDLE;
                end
                default: state <= CS_IDLE;
            endcase
        end
    end

    // outstanding-response count and sticky error from the B channel
    always_ff @(posedge mem_clk or negedge mem_reset_n) begin
        if (!mem_reset_n) begin
            outst <= '0;
            err   <= 1'b0;
        end else begin
            outst <= outst + {3'b0, aw_hs} - {3'b0, b_dec};
            err   <= start_ok ? 1'b0 : (err || (mem_bvalid && mem_bresp != AXI4_OKAY));
        end
    end

endmodule

// File: tb/tb_fb_line_writer.sv
// tb_fb_line_writer: directed frames against an AXI slave model with hand-computed burst lists
module tb_fb_line_writer;
    import vga_pkg::*;

    logic         mem_clk = 1'b0;
    logic         mem_reset_n = 1'b0;
    logic         start = 1'b0;
    logic [26:0]  base_addr = '0;
    logic [12:0]  pitch = '0;
    logic [8:0]   line_words = '0;
    logic [11:0]  line_count = '0;
    logic         busy, done, err;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic [127:0] pix_data = '0;
    logic [3:0]   mem_awid;
    logic [26:0]  mem_awaddr;
    logic [7:0]   mem_awlen;
    logic [2:0]   mem_awsize;
    logic [1:0]   mem_awburst;
    logic         mem_awlock, mem_awvalid;
    logic         mem_awready = 1'b0;
    logic [127:0] mem_wdata;
    logic [15:0]  mem_wstrb;
    logic         mem_wlast, mem_wvalid;
    logic         mem_wready = 1'b0;
    logic [3:0]   mem_bid = '0;
    logic [1:0]   mem_bresp = '0;
    logic         mem_bvalid = 1'b0;
    logic         mem_bready;

    int checks = 0;
    int errors = 0;

    logic clr = 1'b0;
    logic rand_w = 1'b0;
    logic rand_v = 1'b0;
    logic hold_b = 1'b0;
    int   aw_stall = 0;
    int   err_idx = -1;

    logic [26:0] aw_addr_q[$];
    int          aw_len_q[$];
    int          wlast_q[$];
    int          beats = 0;
    int          data_err = 0;
    int          stable_err = 0;
    int          done_cnt = 0;
    int          b_pend = 0;
    int          b_idx = 0;
    int          pix_seq = 0;
    int          aw_cyc = 0;
    logic        aw_hold = 1'b0;
    logic [26:0] hold_addr = '0;
    logic [7:0]  hold_len = '0;

    fb_line_writer dut (
        .mem_clk     (mem_clk),
        .mem_reset_n (mem_reset_n),
        .start       (start),
        .base_addr   (base_addr),
        .pitch       (pitch),
        .line_words  (line_words),
        .line_count  (line_count),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .mem_awid    (mem_awid),
        .mem_awaddr  (mem_awaddr),
        .mem_awlen   (mem_awlen),
        .mem_awsize  (mem_awsize),
        .mem_awburst (mem_awburst),
        .mem_awlock  (mem_awlock),
        .mem_awvalid (mem_awvalid),
        .mem_awready (mem_awready),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb),
        .mem_wlast   (mem_wlast),
        .mem_wvalid  (mem_wvalid),
        .mem_wready  (mem_wready),
        .mem_bid     (mem_bid),
        .mem_bresp   (mem_bresp),
        .mem_bvalid  (mem_bvalid),
        .mem_bready  (mem_bready)
    );

    always #5 mem_clk = ~mem_clk;

    // slave and stream source: drive on the falling edge, observe 1 ns later
    initial forever begin
        @(negedge mem_clk);
        if (clr || !mem_reset_n) begin
            aw_addr_q.delete();
            aw_len_q.delete();
            wlast_q.delete();
            beats = 0; data_err = 0; stable_err = 0; done_cnt = 0;
            b_pend = 0; b_idx = 0; pix_seq = 0; aw_cyc = 0; aw_hold = 1'b0;
        end else begin
            aw_cyc++;
        end
        mem_awready = (aw_cyc >= aw_stall);
        mem_wready  = rand_w ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_valid   = rand_v ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_data    = 128'(pix_seq);
        mem_bvalid  = !hold_b && (b_pend > 0);
        mem_bresp   = (b_idx == err_idx) ? AXI4_SLVERR : AXI4_OKAY;
        #1;
        if (mem_reset_n && !clr) begin
            if (aw_hold && (!mem_awvalid || mem_awaddr != hold_addr || mem_awlen != hold_len))
                stable_err++;
            aw_hold   = mem_awvalid && !mem_awready;
            hold_addr = mem_awaddr;
            hold_len  = mem_awlen;
            if (mem_awvalid && mem_awready) begin
                aw_addr_q.push_back(mem_awaddr);
                aw_len_q.push_back(int'(mem_awlen));
                b_pend++;
            end
            if (mem_bvalid) begin
                b_pend--;
                b_idx++;
            end
            if (mem_wvalid && mem_wready) begin
                if (mem_wdata != 128'(beats)) data_err++;
                if (mem_wlast) wlast_q.push_back(beats);
                beats++;
                pix_seq++;
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_aw(input int i, input logic [26:0] a, input int l);
        check("aw_addr", (i < aw_addr_q.size()) ? 64'(aw_addr_q[i]) : '1, 64'(a));
        check("aw_len", (i < aw_len_q.size()) ? 64'(aw_len_q[i]) : '1, 64'(l));
    endtask

    task automatic start_frame(input logic [26:0] b, input logic [12:0] p,
                               input logic [8:0] lw, input logic [11:0] lc);
        clr = 1'b1;
        @(negedge mem_clk);
        #2;
        clr = 1'b0;
        base_addr = b; pitch = p; line_words = lw; line_count = lc;
        start = 1'b1;
        @(negedge mem_clk);
        #2;
        start = 1'b0;
        check("lat_busy", busy, 1);
        check("lat_awvalid", mem_awvalid, 1);
        check("lat_awaddr", mem_awaddr, b);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge mem_clk);
            if (done_cnt != 0) break;
        end
        repeat (3) @(negedge mem_clk);
        #2;
        check("done_once", done_cnt, 1);
        check("busy_after", busy, 0);
    endtask

    initial begin
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_awvalid", mem_awvalid, 0);
        check("rst_wvalid", mem_wvalid, 0);
        check("rst_wlast", mem_wlast, 0);
        check("rst_awaddr", mem_awaddr, 0);
        check("rst_awlen", mem_awlen, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_awsize", mem_awsize, 3'b100);
        check("rst_awburst", mem_awburst, 2'b01);
        check("rst_bready", mem_bready, 1);
        repeat (2) @(negedge mem_clk);
        mem_reset_n = 1'b1;

        // 51 lines of 80 bytes stay inside the first 4 KB page: one 5-beat burst per line
        start_frame(27'h0, 13'd80, 9'd5, 12'd51);
        wait_done(3000);
        check("basic_aws", aw_addr_q.size(), 51);
        for (int i = 0; i < 51; i++) check_aw(i, 27'(80 * i), 4);
        check("basic_beats", beats, 255);
        check("basic_data", data_err, 0);
        check("basic_err", err, 0);

        // 0xFE0 leaves 2 words before the page end
        start_frame(27'hFE0, 13'd80, 9'd5, 12'd1);
        wait_done(500);
        check("pg_aws", aw_addr_q.size(), 2);
        check_aw(0, 27'hFE0, 1);
        check_aw(1, 27'h1000, 2);
        check("pg_nlast", wlast_q.size(), 2);
        check("pg_last0", wlast_q[0], 1);
        check("pg_last1", wlast_q[1], 4);

        // 40 words split 16/16/8
        start_frame(27'h0, 13'd640, 9'd40, 12'd1);
        wait_done(500);
        check("mb_aws", aw_addr_q.size(), 3);
        check_aw(0, 27'h000, 15);
        check_aw(1, 27'h100, 15);
        check_aw(2, 27'h200, 7);
        check("mb_nlast", wlast_q.size(), 3);
        check("mb_last2", wlast_q[2], 39);

        // AW held off ~10 cycles, random W/stream handshakes
        rand_w = 1'b1; rand_v = 1'b1; aw_stall = 10;
        start_frame(27'h100, 13'h200, 9'd20, 12'd3);
        wait_done(3000);
        check("bp_aws", aw_addr_q.size(), 6);
        check_aw(0, 27'h100, 15);
        check_aw(1, 27'h200, 3);
        check_aw(2, 27'h300, 15);
        check_aw(3, 27'h400, 3);
        check_aw(4, 27'h500, 15);
        check_aw(5, 27'h600, 3);
        check("bp_beats", beats, 60);
        check("bp_data", data_err, 0);
        check("bp_aw_stable", stable_err, 0);
        rand_w = 1'b0; rand_v = 1'b0; aw_stall = 0;

        // withheld responses cap the frame at four bursts in flight
        hold_b = 1'b1;
        start_frame(27'h0, 13'd80, 9'd5, 12'd10);
        repeat (100) @(negedge mem_clk);
        #2;
        check("ost_aws", aw_addr_q.size(), 4);
        check("ost_beats", beats, 20);
        check("ost_busy", busy, 1);
        hold_b = 1'b0;
        wait_done(1000);
        check("ost_aws_end", aw_addr_q.size(), 10);
        check("ost_beats_end", beats, 50);

        // second response is SLVERR
        err_idx = 1;
        start_frame(27'h0, 13'd80, 9'd5, 12'd3);
        wait_done(500);
        check("slv_err", err, 1);
        err_idx = -1;
        start_frame(27'h0, 13'd80, 9'd5, 12'd1);
        check("slv_err_clr", err, 0);
        wait_done(500);
        check("slv_err_stays", err, 0);

        // reset while W beats are being offered
        mem_wready = 1'b0;
        start_frame(27'h0, 13'd80, 9'd5, 12'd1);
        for (int i = 0; i < 50; i++) begin
            @(negedge mem_clk);
            #2;
            if (mem_wvalid) break;
        end
        check("mid_in_w", mem_wvalid, 1);
        mem_reset_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_wvalid", mem_wvalid, 0);
        check("mid_wlast", mem_wlast, 0);
        check("mid_pix_ready", pix_ready, 0);
        check("mid_awvalid", mem_awvalid, 0);
        check("mid_awaddr", mem_awaddr, 0);
        check("mid_awlen", mem_awlen, 0);
        repeat (2) @(negedge mem_clk);
        mem_reset_n = 1'b1;
        start_frame(27'h40, 13'h30, 9'd3, 12'd2);
        wait_done(500);
        check("post_aws", aw_addr_q.size(), 2);
        check_aw(0, 27'h40, 2);
        check_aw(1, 27'h70, 2);
        check("post_beats", beats, 6);
        check("post_data", data_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
